// File: rtl/dmem_if.sv
// Load/store bus between the core's LSU and the data-memory responder.
// Address, size code and store data are valid every cycle; read data returns one cycle later.
interface dmem_if;
  logic [1:0]  d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wr_data;
  logic [31:0] d_rd_data;

  modport master (output d_we, output d_addr, output d_wr_data, input d_rd_data);
  modport slave  (input d_we, input d_addr, input d_wr_data, output d_rd_data);
endinterface

// File: rtl/dmem_responder.sv
// Data-side memory responder: byte-lane RAM, GPIO/cycle-counter MMIO and misaligned-store reporting.
// Read data is registered and right-aligned by the low address bits.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  dmem_if.slave       bus,
  output logic [31:0] gpio_out,
  output logic        err_misalign,
  output logic [31:0] err_addr
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0]   mem_r [DEPTH_WORDS];
  logic [63:0]   cnt_r;
  logic [31:0]   shadow_r;
  logic [31:0]   rd_data_r;
  logic [31:0]   gpio_r;
  logic [31:0]   err_addr_r;
  logic          err_r;

  logic [AW-1:0] idx_s;
  logic          is_mmio_s;
  logic [29:0]   mmio_word_s;
  logic          sel_gpio_s;
  logic          sel_lo_s;
  logic          sel_hi_s;
  logic          is_read_s;
  logic          misalign_s;
  logic [3:0]    be_raw_s;
  logic [3:0]    be_s;
  logic [31:0]   wdata_s;
  logic [31:0]   rd_word_s;
  logic          ram_we_s;

  // Address decode, store-size decode and read-word selection.
  always_comb begin
    idx_s       = bus.d_addr[AW+1:2];
    is_mmio_s   = (bus.d_addr >= MMIO_BASE);
    mmio_word_s = bus.d_addr[31:2] - MMIO_BASE[31:2];
    sel_gpio_s  = is_mmio_s && (mmio_word_s == 30'd0);
    sel_lo_s    = is_mmio_s && (mmio_word_s == 30'd1);
    sel_hi_s    = is_mmio_s && (mmio_word_s == 30'd2);
    is_read_s   = (bus.d_we == 2'b00);

    case (bus.d_we)
      2'b01: begin
        misalign_s = 1'b0;
        be_raw_s   = 4'b0001 << bus.d_addr[1:0];
        wdata_s    = {4{bus.d_wr_data[7:0]}};
      end
      2'b10: begin
        misalign_s = bus.d_addr[0];
        be_raw_s   = bus.d_addr[1] ? 4'b1100 : 4'b0011;
        wdata_s    = {2{bus.d_wr_data[15:0]}};
      end
      2'b11: begin
        misalign_s = (bus.d_addr[1:0] != 2'b00);
        be_raw_s   = 4'b1111;
        wdata_s    = bus.d_wr_data;
      end
      default: begin
        misalign_s = 1'b0;
        be_raw_s   = 4'b0000;
        wdata_s    = 32'h0000_0000;
      end
    endcase

    // A misaligned store must leave every piece of state untouched.
    be_s     = misalign_s ? 4'b0000 : be_raw_s;
    ram_we_s = !is_mmio_s && (be_s != 4'b0000);

    if (sel_gpio_s) begin
      rd_word_s = gpio_r;
    end else if (sel_lo_s) begin
      rd_word_s = cnt_r[31:0];
    end else if (sel_hi_s) begin
      rd_word_s = shadow_r;
    end else if (is_mmio_s) begin
      rd_word_s = 32'h0000_0000;
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // RAM byte-lane writes; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_r[idx_s][i*8 +: 8] <= wdata_s[i*8 +: 8];
        end
      end
    end
  end

  // Counter, CYCLE_HI shadow, read-data register, GPIO lanes and error reporting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= 64'd0;
      shadow_r   <= 32'h0000_0000;
      rd_data_r  <= 32'h0000_0000;
      gpio_r     <= 32'h0000_0000;
      err_r      <= 1'b0;
      err_addr_r <= 32'h0000_0000;
    end else begin
      cnt_r <= cnt_r + 64'd1;
      err_r <= misalign_s;
      if (misalign_s) begin
        err_addr_r <= bus.d_addr;
      end
      if (is_read_s) begin
        rd_data_r <= rd_word_s >> {bus.d_addr[1:0], 3'b000};
        if (sel_lo_s) begin
          shadow_r <= cnt_r[63:32];
        end
      end
      if (sel_gpio_s) begin
        for (int i = 0; i < 4; i++) begin
          if (be_s[i]) begin
            gpio_r[i*8 +: 8] <= wdata_s[i*8 +: 8];
          end
        end
      end
    end
  end

  assign bus.d_rd_data = rd_data_r;
  assign gpio_out      = gpio_r;
  assign err_misalign  = err_r;
  assign err_addr      = err_addr_r;
endmodule
